// File: rtl/pd256_index_decoder.sv
// Two-stage 8-bit to 256-bit one-hot index decoder with valid/ready handshakes,
// plus a running OR mask and a saturating count of accepted non-zero words.
module pd256_index_decoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_idx,
   input  logic             in_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [255:0]     out_oh,
   output logic [7:0]       out_idx,
   output logic             out_zero,
   input  logic             mask_clr,
   output logic [255:0]     mask,
   output logic [CNT_W-1:0] dec_cnt
);

   localparam int unsigned IDX_W = 8;
   localparam int unsigned OH_W  = 256;
   localparam int unsigned GRP_N = 4;
   localparam int unsigned POS_N = 64;
   localparam int unsigned POS_W = 6;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             s1_valid;
   logic [GRP_N-1:0] s1_grp;
   logic [POS_W-1:0] s1_pos;
   logic [IDX_W-1:0] s1_idx;
   logic             s1_v;

   logic             s2_adv;
   logic             fire;
   logic [OH_W-1:0]  oh_c;

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;
   assign fire     = out_valid && out_ready;

   // Stage 1: group one-hot and in-group position, captured on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_grp   <= '0;
         s1_pos   <= '0;
         s1_idx   <= '0;
         s1_v     <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_grp <= in_v ? (GRP_N'(1) << in_idx[7:6]) : '0;
            s1_pos <= in_idx[POS_W-1:0];
            s1_idx <= in_idx;
            s1_v   <= in_v;
         end
      end
   end

   // Full decode: bit 64*g+k is set when group g is selected and position is k
   always_comb begin
      oh_c = '0;
      for (int g = 0; g < int'(GRP_N); g++) begin
         for (int k = 0; k < int'(POS_N); k++) begin
            oh_c[int'(POS_N) * g + k] = s1_grp[g] && (s1_pos == POS_W'(k));
         end
      end
   end

   // Stage 2: output register; out_oh is cleared whenever it drains empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_oh    <= '0;
         out_idx   <= '0;
         out_zero  <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_oh   <= oh_c;
            out_idx  <= s1_idx;
            out_zero <= !s1_v;
         end else begin
            out_oh   <= '0;
         end
      end
   end

   // History: a clear coinciding with a fire keeps only the firing word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask    <= '0;
         dec_cnt <= '0;
      end else if (mask_clr) begin
         mask    <= fire ? out_oh : '0;
         dec_cnt <= (fire && !out_zero) ? CNT_W'(1) : '0;
      end else if (fire) begin
         mask <= mask | out_oh;
         if (!out_zero && (dec_cnt != CNT_MAX)) begin
            dec_cnt <= dec_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pd256_index_decoder.sv
// Directed bench for pd256_index_decoder: boundary decodes, zero words,
// backpressure, mask clear, counter saturation and mid-flight reset.
module tb_pd256_index_decoder;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_idx;
   logic             in_v;
   logic             out_valid;
   logic             out_ready;
   logic [255:0]     out_oh;
   logic [7:0]       out_idx;
   logic             out_zero;
   logic             mask_clr;
   logic [255:0]     mask;
   logic [CNT_W-1:0] dec_cnt;

   int checks = 0;
   int errors = 0;

   pd256_index_decoder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_idx(in_idx), .in_v(in_v), .out_valid(out_valid), .out_ready(out_ready),
      .out_oh(out_oh), .out_idx(out_idx), .out_zero(out_zero),
      .mask_clr(mask_clr), .mask(mask), .dec_cnt(dec_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] bit1(input int i);
      bit1 = 256'(1) << i;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; in_idx = 8'd99; in_v = 1'b1;
      out_ready = 1'b1; mask_clr = 1'b0;
      tick(); tick(); tick();
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_out_oh", out_oh, '0);
      chk("rst_out_idx", 256'(out_idx), 256'(0));
      chk("rst_mask", mask, '0);
      chk("rst_dec_cnt", 256'(dec_cnt), 256'(0));

      // boundary stream 0,63,64,255
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1 chk("post_rst_in_ready", 256'(in_ready), 256'(1));
      in_valid = 1'b1; in_idx = 8'd0;
      tick();
      chk("lat_not_yet", 256'(out_valid), 256'(0));
      in_idx = 8'd63;
      tick();
      chk("b0_valid", 256'(out_valid), 256'(1));
      chk("b0_oh", out_oh, bit1(0));
      chk("b0_idx", 256'(out_idx), 256'(0));
      in_idx = 8'd64;
      tick();
      chk("b63_oh", out_oh, bit1(63));
      in_idx = 8'd255;
      tick();
      chk("b64_oh", out_oh, bit1(64));
      in_valid = 1'b0;
      tick();
      chk("b255_oh", out_oh, bit1(255));
      chk("b255_zero", 256'(out_zero), 256'(0));
      tick();
      chk("drain_valid", 256'(out_valid), 256'(0));
      chk("drain_oh", out_oh, '0);
      chk("stream_cnt", 256'(dec_cnt), 256'(4));
      chk("stream_mask", mask, bit1(0) | bit1(63) | bit1(64) | bit1(255));

      // in_v = 0 word
      in_valid = 1'b1; in_idx = 8'd17; in_v = 1'b0;
      tick();
      in_valid = 1'b0; in_v = 1'b1;
      tick();
      chk("z_valid", 256'(out_valid), 256'(1));
      chk("z_oh", out_oh, '0);
      chk("z_zero", 256'(out_zero), 256'(1));
      chk("z_idx", 256'(out_idx), 256'(17));
      tick();
      chk("z_cnt", 256'(dec_cnt), 256'(4));
      chk("z_mask", mask, bit1(0) | bit1(63) | bit1(64) | bit1(255));

      // backpressure: out_ready low for 6 cycles while streaming 10,11,12
      out_ready = 1'b0;
      in_valid = 1'b1; in_idx = 8'd10;
      tick();
      in_idx = 8'd11;
      chk("bp_ready_1st", 256'(in_ready), 256'(1));
      tick();
      in_idx = 8'd12;
      chk("bp_in_ready_low", 256'(in_ready), 256'(0));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_hold_valid", 256'(out_valid), 256'(1));
         chk("bp_hold_oh", out_oh, bit1(10));
         chk("bp_hold_in_ready", 256'(in_ready), 256'(0));
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 256'(in_ready), 256'(1));
      tick();
      in_valid = 1'b0;
      chk("bp_seq11", out_oh, bit1(11));
      chk("bp_seq11_idx", 256'(out_idx), 256'(11));
      tick();
      chk("bp_seq12", out_oh, bit1(12));
      chk("bp_seq12_valid", 256'(out_valid), 256'(1));
      tick();
      chk("bp_drained", 256'(out_valid), 256'(0));
      chk("bp_cnt", 256'(dec_cnt), 256'(7));

      // mask_clr coinciding with fire of 200
      in_valid = 1'b1; in_idx = 8'd200;
      tick();
      in_valid = 1'b0;
      tick();
      mask_clr = 1'b1;
      tick();
      mask_clr = 1'b0;
      chk("clr_fire_mask", mask, bit1(200));
      chk("clr_fire_cnt", 256'(dec_cnt), 256'(1));
      mask_clr = 1'b1;
      tick();
      mask_clr = 1'b0;
      chk("clr_mask", mask, '0);
      chk("clr_cnt", 256'(dec_cnt), 256'(0));

      // saturation: 16 words then one more
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_idx = 8'(100 + i);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("sat_cnt16", 256'(dec_cnt), 256'(15));
      in_valid = 1'b1; in_idx = 8'd7;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("sat_cnt17", 256'(dec_cnt), 256'(15));
      chk("sat_mask_bit7", 256'(mask[7]), 256'(1));

      // reset with two words in flight
      in_valid = 1'b1; in_idx = 8'd30;
      tick();
      in_idx = 8'd31;
      tick();
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 256'(out_valid), 256'(0));
      chk("mid_rst_mask", mask, '0);
      chk("mid_rst_cnt", 256'(dec_cnt), 256'(0));
      tick();
      rst_n = 1'b1;
      #1 chk("rel_in_ready", 256'(in_ready), 256'(1));
      in_valid = 1'b1; in_idx = 8'd5;
      tick();
      in_valid = 1'b0;
      chk("r5_lat1", 256'(out_valid), 256'(0));
      tick();
      chk("r5_valid", 256'(out_valid), 256'(1));
      chk("r5_oh", out_oh, bit1(5));
      chk("r5_idx", 256'(out_idx), 256'(5));
      tick();
      chk("r5_cnt", 256'(dec_cnt), 256'(1));
      chk("r5_empty", 256'(out_valid), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
